video_timing: RTL and testbench
===============================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 40, meaning horizontal front-porch pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 128, meaning horizontal sync-pulse pixels.
REQ-004 The block SHALL have parameter H_BACK, default 88, meaning horizontal back-porch pixels (line total 1056).
REQ-005 The block SHALL have parameters V_ACTIVE 600, V_FRONT 1, V_SYNC 4 and V_BACK 23, meaning vertical equivalents in lines (frame total 628).
REQ-006 The block SHALL have parameters HS_POL and VS_POL, each default 1, meaning active sync level (1 = active-high).
REQ-007 The block SHALL have parameters X_W, default 11, and Y_W, default 10, meaning coordinate widths; each SHALL hold its axis total minus 1.
REQ-008 The block SHALL have port PIXEL_CLOCK  in  1  pixel clock; it is the only clock.
REQ-009 The block SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-010 The block SHALL have port CLK_EN  in  1  pixel advance enable; when low, all state holds.
REQ-011 The block SHALL have ports SCREEN_X  out  X_W and SCREEN_Y  out  Y_W, meaning current position, registered.
REQ-012 The block SHALL have ports Hs  out  1 and Vs  out  1, meaning syncs at the configured polarity.
REQ-013 The block SHALL have port ON_SCREEN  out  1, meaning the position is inside the active area.
REQ-014 The block SHALL have ports LINE_START  out  1 and FRAME_START  out  1, meaning one-pixel strobes at X=0 and at X=0,Y=0.
REQ-015 The block SHALL have port VBLANK  out  1, meaning Y >= V_ACTIVE.

Function
REQ-016 Internal counters h,v SHALL advance only on PIXEL_CLOCK edges with CLK_EN=1: h wraps H_TOTAL-1 -> 0; v increments only on h wrap and wraps V_TOTAL-1 -> 0.
REQ-017 H_TOTAL SHALL equal H_ACTIVE+H_FRONT+H_SYNC+H_BACK, and V_TOTAL the vertical equivalent; all comparisons SHALL be full-width unsigned with no truncation.
REQ-018 All outputs SHALL be registered from the counter values with exactly 1 enabled cycle of latency and mutually aligned: SCREEN_X/Y equal the counter value they decode.
REQ-019 Sync SHALL be active for H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, and vertically likewise; Hs SHALL equal HS_POL when active and ~HS_POL otherwise.
REQ-020 ON_SCREEN SHALL equal (x < H_ACTIVE) && (y < V_ACTIVE).
REQ-021 LINE_START SHALL be high for x==0 on every line; FRAME_START SHALL be high only when x==0 and y==0.
REQ-022 When CLK_EN=0, all outputs, strobes included, SHALL hold their prior values; strobes therefore last exactly one enabled pixel.
REQ-023 Parameter sets with any field 0, or with a total exceeding 2^X_W or 2^Y_W, SHALL be rejected at elaboration.

Reset
REQ-024 RESET_N=0 SHALL immediately force h=v=0, SCREEN_X=SCREEN_Y=0, Hs=~HS_POL, Vs=~VS_POL, ON_SCREEN=0, LINE_START=0, FRAME_START=0 and VBLANK=0, regardless of clock.
REQ-025 On the first enabled edge after release, outputs SHALL decode (0,0), giving FRAME_START=1, LINE_START=1 and ON_SCREEN=1; counters SHALL move to (1,0).
REQ-026 Reset asserted mid-frame SHALL abandon the frame, and the next frame SHALL start at (0,0) with no partial sync pulse retained.

Structure
REQ-027 A shared package video_pkg SHALL hold localparam timing sets for 800x600@60 (the defaults) and 640x480@60 (640/16/96/48, 480/10/2/33, negative polarity).
REQ-028 One sub-module, video_timing_axis, SHALL be instantiated twice (H, V) and SHALL provide a counter with step enable, wrap strobe and sync/active decode parameterised by its four lengths.

Verification
REQ-029 With defaults and CLK_EN=1, the bench SHALL check Hs high for SCREEN_X 840..967 (128 cycles), a line period of 1056 cycles, and a frame of 663168 cycles between FRAME_START pulses.
REQ-030 With a small set H 8/2/3/3 and V 4/1/2/1, the bench SHALL check the full 128-cycle frame against a reference model, including Vs over lines 5..6 and VBLANK over lines 4..7.
REQ-031 With HS_POL=VS_POL=0, Hs and Vs SHALL idle at 1, pulse at 0, and read 1 during reset.
REQ-032 Toggling CLK_EN 1-in-3 SHALL leave the output sequence identical to the always-enabled run, sampled on enabled edges, with each strobe lasting 3 clocks.
REQ-033 Asserting RESET_N=0 at (500,300) asynchronously between edges SHALL zero all outputs immediately, and the first enabled edge after release SHALL give FRAME_START=1.
REQ-034 At wrap (1055,627) -> (0,0), SCREEN_Y SHALL go to 0 on the same cycle SCREEN_X goes to 0, with FRAME_START=1 and VBLANK=0.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared timing sets and helpers for the video timing generator
package video_pkg;

  // 800x600@60, 40 MHz pixel clock
  localparam int unsigned SVGA_H_ACTIVE = 800;
  localparam int unsigned SVGA_H_FRONT  = 40;
  localparam int unsigned SVGA_H_SYNC   = 128;
  localparam int unsigned SVGA_H_BACK   = 88;
  localparam int unsigned SVGA_V_ACTIVE = 600;
  localparam int unsigned SVGA_V_FRONT  = 1;
  localparam int unsigned SVGA_V_SYNC   = 4;
  localparam int unsigned SVGA_V_BACK   = 23;
  localparam bit          SVGA_HS_POL   = 1'b1;
  localparam bit          SVGA_VS_POL   = 1'b1;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam int unsigned VGA_H_ACTIVE  = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_ACTIVE  = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam bit          VGA_HS_POL    = 1'b0;
  localparam bit          VGA_VS_POL    = 1'b0;

  function automatic int unsigned axis_total(int unsigned active, int unsigned front,
                                             int unsigned sync, int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// rtl/video_timing_if.sv - output bundle of the video timing generator
interface video_timing_if #(
  parameter int X_W = 11,
  parameter int Y_W = 10
);
  logic [X_W-1:0] screen_x;
  logic [Y_W-1:0] screen_y;
  logic           hs;
  logic           vs;
  logic           on_screen;
  logic           line_start;
  logic           frame_start;
  logic           vblank;

  modport master (
    output screen_x, screen_y, hs, vs, on_screen, line_start, frame_start, vblank
  );

  modport slave (
    input screen_x, screen_y, hs, vs, on_screen, line_start, frame_start, vblank
  );
endinterface

// File: rtl/video_timing_axis.sv
// rtl/video_timing_axis.sv - one timing axis: wrapping counter with sync/active decode
module video_timing_axis
  import video_pkg::*;
#(
  parameter int          W      = 11,
  parameter int unsigned ACTIVE = 800,
  parameter int unsigned FRONT  = 40,
  parameter int unsigned SYNC   = 128,
  parameter int unsigned BACK   = 88
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync_act,
  output logic         active
);

  localparam int unsigned TOTAL   = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam int unsigned SYNC_LO = ACTIVE + FRONT;
  localparam int unsigned SYNC_HI = ACTIVE + FRONT + SYNC;

  if (ACTIVE == 0 || FRONT == 0 || SYNC == 0 || BACK == 0) begin : g_zero_len
    $error("video_timing_axis: every timing segment must be non-zero");
  end
  if (64'(TOTAL) > (64'd1 << W)) begin : g_too_wide
    $error("video_timing_axis: axis total does not fit the coordinate width");
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic [31:0]  cnt_w;

  // Decodes compare at 32 bits so no parameter is ever truncated to W.
  assign cnt_w    = 32'(cnt_q);
  assign cnt      = cnt_q;
  assign wrap     = (cnt_w == TOTAL - 1);
  assign sync_act = (cnt_w >= SYNC_LO) && (cnt_w < SYNC_HI);
  assign active   = (cnt_w < ACTIVE);

  // Next count: hold unless stepped, return to zero after the last position
  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster timing generator with registered, aligned outputs
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
  parameter int unsigned H_FRONT  = SVGA_H_FRONT,
  parameter int unsigned H_SYNC   = SVGA_H_SYNC,
  parameter int unsigned H_BACK   = SVGA_H_BACK,
  parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
  parameter int unsigned V_FRONT  = SVGA_V_FRONT,
  parameter int unsigned V_SYNC   = SVGA_V_SYNC,
  parameter int unsigned V_BACK   = SVGA_V_BACK,
  parameter bit          HS_POL   = SVGA_HS_POL,
  parameter bit          VS_POL   = SVGA_VS_POL,
  parameter int          X_W      = 11,
  parameter int          Y_W      = 10
) (
  input  logic           PIXEL_CLOCK,
  input  logic           RESET_N,
  input  logic           CLK_EN,
  output logic [X_W-1:0] SCREEN_X,
  output logic [Y_W-1:0] SCREEN_Y,
  output logic           Hs,
  output logic           Vs,
  output logic           ON_SCREEN,
  output logic           LINE_START,
  output logic           FRAME_START,
  output logic           VBLANK
);

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           h_wrap, h_sync, h_act;
  logic           v_wrap_unused, v_sync, v_act;

  video_timing_axis #(
    .W(X_W), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk(PIXEL_CLOCK), .rst_n(RESET_N), .step(CLK_EN),
    .cnt(h_cnt), .wrap(h_wrap), .sync_act(h_sync), .active(h_act)
  );

  // The line counter only moves on the pixel that closes a line.
  video_timing_axis #(
    .W(Y_W), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk(PIXEL_CLOCK), .rst_n(RESET_N), .step(CLK_EN & h_wrap),
    .cnt(v_cnt), .wrap(v_wrap_unused), .sync_act(v_sync), .active(v_act)
  );

  logic [X_W-1:0] screen_x_q, screen_x_d;
  logic [Y_W-1:0] screen_y_q, screen_y_d;
  logic hs_q, hs_d, vs_q, vs_d;
  logic on_screen_q, on_screen_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic vblank_q, vblank_d;

  // Decode the current counters into next outputs; everything holds while disabled
  always_comb begin
    screen_x_d    = screen_x_q;
    screen_y_d    = screen_y_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    on_screen_d   = on_screen_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    vblank_d      = vblank_q;
    if (CLK_EN) begin
      screen_x_d    = h_cnt;
      screen_y_d    = v_cnt;
      hs_d          = h_sync ? HS_POL : ~HS_POL;
      vs_d          = v_sync ? VS_POL : ~VS_POL;
      on_screen_d   = h_act & v_act;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      vblank_d      = ~v_act;
    end
  end

  // Output registers; reset drives syncs to their idle level
  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      screen_x_q    <= '0;
      screen_y_q    <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      on_screen_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      screen_x_q    <= screen_x_d;
      screen_y_q    <= screen_y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      on_screen_q   <= on_screen_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

  assign SCREEN_X    = screen_x_q;
  assign SCREEN_Y    = screen_y_q;
  assign Hs          = hs_q;
  assign Vs          = vs_q;
  assign ON_SCREEN   = on_screen_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;
  assign VBLANK      = vblank_q;

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - self-checking bench for video_timing
module tb_video_timing;

  logic clk;
  logic rst_n;
  logic rst_a;
  logic en_e;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  video_timing_if #(.X_W(11), .Y_W(10)) if_a ();
  video_timing_if #(.X_W(11), .Y_W(3))  if_w ();
  video_timing_if #(.X_W(4),  .Y_W(3))  if_s ();
  video_timing_if #(.X_W(4),  .Y_W(3))  if_e ();
  video_timing_if #(.X_W(4),  .Y_W(3))  if_n ();

  // Default 800x600 timing
  video_timing dut_a (
    .PIXEL_CLOCK(clk), .RESET_N(rst_a), .CLK_EN(1'b1),
    .SCREEN_X(if_a.screen_x), .SCREEN_Y(if_a.screen_y), .Hs(if_a.hs), .Vs(if_a.vs),
    .ON_SCREEN(if_a.on_screen), .LINE_START(if_a.line_start),
    .FRAME_START(if_a.frame_start), .VBLANK(if_a.vblank)
  );

  // Default line, short 8-line frame
  video_timing #(
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .Y_W(3)
  ) dut_w (
    .PIXEL_CLOCK(clk), .RESET_N(rst_n), .CLK_EN(1'b1),
    .SCREEN_X(if_w.screen_x), .SCREEN_Y(if_w.screen_y), .Hs(if_w.hs), .Vs(if_w.vs),
    .ON_SCREEN(if_w.on_screen), .LINE_START(if_w.line_start),
    .FRAME_START(if_w.frame_start), .VBLANK(if_w.vblank)
  );

  video_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .X_W(4), .Y_W(3)
  ) dut_s (
    .PIXEL_CLOCK(clk), .RESET_N(rst_n), .CLK_EN(1'b1),
    .SCREEN_X(if_s.screen_x), .SCREEN_Y(if_s.screen_y), .Hs(if_s.hs), .Vs(if_s.vs),
    .ON_SCREEN(if_s.on_screen), .LINE_START(if_s.line_start),
    .FRAME_START(if_s.frame_start), .VBLANK(if_s.vblank)
  );

  video_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .X_W(4), .Y_W(3)
  ) dut_e (
    .PIXEL_CLOCK(clk), .RESET_N(rst_n), .CLK_EN(en_e),
    .SCREEN_X(if_e.screen_x), .SCREEN_Y(if_e.screen_y), .Hs(if_e.hs), .Vs(if_e.vs),
    .ON_SCREEN(if_e.on_screen), .LINE_START(if_e.line_start),
    .FRAME_START(if_e.frame_start), .VBLANK(if_e.vblank)
  );

  video_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .X_W(4), .Y_W(3),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .PIXEL_CLOCK(clk), .RESET_N(rst_n), .CLK_EN(1'b1),
    .SCREEN_X(if_n.screen_x), .SCREEN_Y(if_n.screen_y), .Hs(if_n.hs), .Vs(if_n.vs),
    .ON_SCREEN(if_n.on_screen), .LINE_START(if_n.line_start),
    .FRAME_START(if_n.frame_start), .VBLANK(if_n.vblank)
  );

  // Packs a position and flags as x<<16 | y<<8 | {hs,vs,on,ls,fs,vb}
  function automatic int enc(int x, int y, logic hs, logic vs, logic on,
                             logic ls, logic fs, logic vb);
    return (x << 16) | (y << 8) | {26'd0, hs, vs, on, ls, fs, vb};
  endfunction

  function automatic int act_a();
    return enc(int'(if_a.screen_x), int'(if_a.screen_y), if_a.hs, if_a.vs, if_a.on_screen,
               if_a.line_start, if_a.frame_start, if_a.vblank);
  endfunction
  function automatic int act_w();
    return enc(int'(if_w.screen_x), int'(if_w.screen_y), if_w.hs, if_w.vs, if_w.on_screen,
               if_w.line_start, if_w.frame_start, if_w.vblank);
  endfunction
  function automatic int act_s();
    return enc(int'(if_s.screen_x), int'(if_s.screen_y), if_s.hs, if_s.vs, if_s.on_screen,
               if_s.line_start, if_s.frame_start, if_s.vblank);
  endfunction
  function automatic int act_e();
    return enc(int'(if_e.screen_x), int'(if_e.screen_y), if_e.hs, if_e.vs, if_e.on_screen,
               if_e.line_start, if_e.frame_start, if_e.vblank);
  endfunction
  function automatic int act_n();
    return enc(int'(if_n.screen_x), int'(if_n.screen_y), if_n.hs, if_n.vs, if_n.on_screen,
               if_n.line_start, if_n.frame_start, if_n.vblank);
  endfunction

  // Reference for the 16x8 small timing at raster position p (row-major)
  function automatic int model_small(int p, bit pol);
    int q, x, y;
    logic hs_a, vs_a;
    q = p % 128;
    x = q % 16;
    y = q / 16;
    hs_a = (x >= 10) && (x < 13);
    vs_a = (y >= 5) && (y < 7);
    return enc(x, y, pol ? hs_a : ~hs_a, pol ? vs_a : ~vs_a, (x < 8) && (y < 4),
               (x == 0), (x == 0) && (y == 0), (y >= 4));
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int steps;
    int exp;
  } vec_t;

  task automatic run_table();
    vec_t tbl [13];
    tbl[0]  = '{1,  enc(0,  0, 0, 0, 1, 1, 1, 0)};
    tbl[1]  = '{7,  enc(7,  0, 0, 0, 1, 0, 0, 0)};
    tbl[2]  = '{1,  enc(8,  0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{2,  enc(10, 0, 1, 0, 0, 0, 0, 0)};
    tbl[4]  = '{2,  enc(12, 0, 1, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1,  enc(13, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{3,  enc(0,  1, 0, 0, 1, 1, 0, 0)};
    tbl[7]  = '{48, enc(0,  4, 0, 0, 0, 1, 0, 1)};
    tbl[8]  = '{16, enc(0,  5, 0, 1, 0, 1, 0, 1)};
    tbl[9]  = '{26, enc(10, 6, 1, 1, 0, 0, 0, 1)};
    tbl[10] = '{6,  enc(0,  7, 0, 0, 0, 1, 0, 1)};
    tbl[11] = '{15, enc(15, 7, 0, 0, 0, 0, 0, 1)};
    tbl[12] = '{1,  enc(0,  0, 0, 0, 1, 1, 1, 0)};
    for (int i = 0; i < 13; i++) begin
      repeat (tbl[i].steps) @(negedge clk);
      chk($sformatf("s_table[%0d]", i), act_s(), tbl[i].exp);
    end
  endtask

  task automatic run_model();
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      chk($sformatf("s_model[%0d]", k), act_s(), model_small(k - 1, 1'b1));
    end
  endtask

  task automatic run_neg();
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      chk($sformatf("n_model[%0d]", k), act_n(), model_small(k - 1, 1'b0));
    end
  endtask

  task automatic run_en();
    int j;
    int fs_cnt;
    j = 0;
    fs_cnt = 0;
    for (int k = 1; k <= 384; k++) begin
      en_e = (k % 3 == 1);
      @(negedge clk);
      if (en_e) j++;
      chk($sformatf("e_seq[%0d]", k), act_e(), model_small(j - 1, 1'b1));
      if (k <= 48 && if_e.frame_start) fs_cnt++;
    end
    en_e = 1'b0;
    chk("e_fs_len", fs_cnt, 3);
  endtask

  task automatic run_def();
    int n;
    int last_x;
    n = 0;
    while (!if_a.hs && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("a_hs_first_x", int'(if_a.screen_x), 840);
    chk("a_hs_first_edge", n, 841);
    n = 0;
    last_x = -1;
    while (if_a.hs && n < 300) begin
      last_x = int'(if_a.screen_x);
      n++;
      @(negedge clk);
    end
    chk("a_hs_len", n, 128);
    chk("a_hs_last_x", last_x, 967);
    n = 0;
    while (!if_a.line_start && n < 1200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n = 1;
    while (!if_a.line_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("a_line_period", n, 1056);
    n = 0;
    while (int'(if_a.screen_x) != 500 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("a_pre_rst_x", int'(if_a.screen_x), 500);
    #2;
    rst_a = 1'b0;
    #1;
    chk("a_async_rst", act_a(), enc(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("a_rst_hold", act_a(), enc(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    rst_a = 1'b1;
    @(negedge clk);
    chk("a_after_rst", act_a(), enc(0, 0, 0, 0, 1, 1, 1, 0));
    @(negedge clk);
    chk("a_after_rst_next", act_a(), enc(1, 0, 0, 0, 1, 0, 0, 0));
  endtask

  task automatic run_wrap();
    int n;
    int prev;
    @(negedge clk);
    chk("w_fs_first", act_w(), enc(0, 0, 0, 0, 1, 1, 1, 0));
    n = 0;
    prev = act_w();
    do begin
      prev = act_w();
      @(negedge clk);
      n++;
    end while (!if_w.frame_start && n < 9000);
    chk("w_frame_period", n, 8448);
    chk("w_before_wrap", prev, enc(1055, 7, 0, 0, 0, 0, 0, 1));
    chk("w_wrap", act_w(), enc(0, 0, 0, 0, 1, 1, 1, 0));
  endtask

  initial begin
    rst_n = 1'b0;
    rst_a = 1'b0;
    en_e  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_state", act_a(), enc(0, 0, 0, 0, 0, 0, 0, 0));
    chk("rst_s_state", act_s(), enc(0, 0, 0, 0, 0, 0, 0, 0));
    chk("rst_n_state", act_n(), enc(0, 0, 1, 1, 0, 0, 0, 0));
    #1;
    rst_n = 1'b1;
    rst_a = 1'b1;
    fork
      run_table();
      run_model();
      run_neg();
      run_en();
      run_def();
      run_wrap();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
